// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scan-out has priority, CPU is bounded by a starvation guard,
// and CPU writes are posted through a one-entry buffer. Optional stall statistics: VRAM_ARB_STATS_EN.
module vram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int MAX_DISP_RUN = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_rvalid_o,
    input  logic              disp_req_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    output logic              disp_gnt_o,
    output logic [DATA_W-1:0] disp_rdata_o,
    output logic              disp_rvalid_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_q_i
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt_o
`endif
);

    localparam logic [7:0] RUN_MAX = 8'(MAX_DISP_RUN);

    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [7:0]        run_cnt_q, run_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              cpu_rvalid_q, disp_rvalid_q;
    logic              fwd_q;
    logic [DATA_W-1:0] fwd_data_q;

    logic crd_cand, fwd_hit, cpu_pend, starve;
    logic disp_gnt, drain_gnt, crd_gnt, fwd_gnt, wr_gnt;

    // Grants are forced low while reset is asserted so every output reads 0.
    always_comb begin
        crd_cand  = 1'b0;
        fwd_hit   = 1'b0;
        cpu_pend  = 1'b0;
        starve    = 1'b0;
        disp_gnt  = 1'b0;
        drain_gnt = 1'b0;
        crd_gnt   = 1'b0;
        fwd_gnt   = 1'b0;
        wr_gnt    = 1'b0;
        if (!rst_i) begin
            crd_cand  = cpu_req_i && !cpu_we_i && !wb_valid_q;
            fwd_hit   = cpu_req_i && !cpu_we_i && wb_valid_q && (cpu_addr_i == wb_addr_q);
            cpu_pend  = wb_valid_q || crd_cand;
            starve    = cpu_pend && (run_cnt_q >= RUN_MAX);
            disp_gnt  = disp_req_i && !starve;
            drain_gnt = wb_valid_q && !disp_gnt;
            crd_gnt   = crd_cand && !disp_gnt;
            // Forwarding is held off during a display slot so the two rvalid pulses never coincide.
            fwd_gnt   = fwd_hit && !disp_gnt;
            wr_gnt    = cpu_req_i && cpu_we_i && (!wb_valid_q || drain_gnt);
        end
    end

    always_comb begin
        if (disp_gnt) begin
            mem_addr_o = disp_addr_i;
        end else if (drain_gnt) begin
            mem_addr_o = wb_addr_q;
        end else if (crd_gnt) begin
            mem_addr_o = cpu_addr_i;
        end else begin
            mem_addr_o = mem_addr_q;
        end
    end

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (wr_gnt) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = cpu_addr_i;
            wb_data_d  = cpu_wdata_i;
        end else if (drain_gnt) begin
            wb_valid_d = 1'b0;
        end

        run_cnt_d = run_cnt_q;
        if (drain_gnt || crd_gnt || fwd_gnt || wr_gnt || !cpu_pend) begin
            run_cnt_d = 8'd0;
        end else if (disp_gnt && (run_cnt_q < RUN_MAX)) begin
            run_cnt_d = run_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid_q    <= 1'b0;
            wb_addr_q     <= '0;
            wb_data_q     <= '0;
            run_cnt_q     <= 8'd0;
            mem_addr_q    <= '0;
            cpu_rvalid_q  <= 1'b0;
            disp_rvalid_q <= 1'b0;
            fwd_q         <= 1'b0;
            fwd_data_q    <= '0;
        end else begin
            wb_valid_q    <= wb_valid_d;
            wb_addr_q     <= wb_addr_d;
            wb_data_q     <= wb_data_d;
            run_cnt_q     <= run_cnt_d;
            mem_addr_q    <= mem_addr_o;
            cpu_rvalid_q  <= crd_gnt || fwd_gnt;
            disp_rvalid_q <= disp_gnt;
            fwd_q         <= fwd_gnt;
            if (fwd_gnt) begin
                fwd_data_q <= wb_data_q;
            end
        end
    end

    assign cpu_gnt_o     = wr_gnt || fwd_gnt || crd_gnt;
    assign disp_gnt_o    = disp_gnt;
    assign mem_we_o      = drain_gnt;
    assign mem_wdata_o   = wb_data_q;
    assign cpu_rvalid_o  = cpu_rvalid_q;
    assign disp_rvalid_o = disp_rvalid_q;
    assign cpu_rdata_o   = !cpu_rvalid_q ? '0 : (fwd_q ? fwd_data_q : mem_q_i);
    assign disp_rdata_o  = rst_i ? '0 : mem_q_i;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= 16'd0;
        end else if (cpu_req_i && !cpu_gnt_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model, golden memory and read-data scoreboards.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        disp_req;
    logic [15:0] disp_addr;
    logic        disp_gnt;
    logic [7:0]  disp_rdata;
    logic        disp_rvalid;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_q;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] ram    [0:65535];
    logic [7:0] golden [0:65535];
    logic [7:0] dq [$];
    logic [7:0] cq [$];

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_DISP_RUN(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cpu_req_i    (cpu_req),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_gnt_o    (cpu_gnt),
        .cpu_rdata_o  (cpu_rdata),
        .cpu_rvalid_o (cpu_rvalid),
        .disp_req_i   (disp_req),
        .disp_addr_i  (disp_addr),
        .disp_gnt_o   (disp_gnt),
        .disp_rdata_o (disp_rdata),
        .disp_rvalid_o(disp_rvalid),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_we_o     (mem_we),
        .mem_q_i      (mem_q)
`ifdef VRAM_ARB_STATS_EN
        ,
        .stall_cnt_o  (stall_cnt)
`endif
    );

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Synchronous RAM macro model, read-before-write, one cycle latency.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_q <= ram[mem_addr];
    end

    // Expected read data is queued when a request is accepted.
    always @(negedge clk) begin
        if (!rst) begin
            if (disp_gnt) dq.push_back(golden[disp_addr]);
            if (cpu_gnt && !cpu_we) cq.push_back(golden[cpu_addr]);
            if (cpu_gnt && cpu_we) golden[cpu_addr] = cpu_wdata;
        end
    end

    always @(posedge clk) begin
        logic [7:0] exp_v;
        #2;
        if (!rst) begin
            total++;
            if ((disp_rvalid && cpu_rvalid) !== 1'b0) begin
                bad++;
                $display("FAIL both_rvalid: got disp=%0b cpu=%0b want not both", disp_rvalid, cpu_rvalid);
            end
            if (disp_rvalid) begin
                total++;
                if (dq.size() == 0) begin
                    bad++;
                    $display("FAIL disp_rvalid_spurious: got rvalid=1 want no pending read");
                end else begin
                    exp_v = dq.pop_front();
                    if (disp_rdata !== exp_v) begin
                        bad++;
                        $display("FAIL disp_rdata: got %h want %h", disp_rdata, exp_v);
                    end
                end
            end
            if (cpu_rvalid) begin
                total++;
                if (cq.size() == 0) begin
                    bad++;
                    $display("FAIL cpu_rvalid_spurious: got rvalid=1 want no pending read");
                end else begin
                    exp_v = cq.pop_front();
                    if (cpu_rdata !== exp_v) begin
                        bad++;
                        $display("FAIL cpu_rdata: got %h want %h", cpu_rdata, exp_v);
                    end
                end
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        disp_req = 1'b0;
    endtask

    task automatic test_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0700; cpu_wdata = 8'hEE;
        @(negedge clk);
        total++;
        if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL rst_pre_write_gnt: got %b want 1", cpu_gnt); end
        cyc();
        cpu_req = 1'b0;
        @(negedge clk);
        total++;
        if (mem_we !== 1'b1) begin bad++; $display("FAIL rst_pre_drain: got %b want 1", mem_we); end
        rst = 1'b1;
        golden[16'h0700] = pat(16'h0700);
        dq.delete();
        cq.delete();
        #1;
        total++;
        if ({disp_gnt, cpu_gnt, mem_we, cpu_rvalid, disp_rvalid, mem_addr, mem_wdata, cpu_rdata, disp_rdata} !== '0) begin
            bad++;
            $display("FAIL rst_outputs: got dg=%b cg=%b we=%b crv=%b drv=%b ma=%h wd=%h crd=%h drd=%h want all 0",
                     disp_gnt, cpu_gnt, mem_we, cpu_rvalid, disp_rvalid, mem_addr, mem_wdata, cpu_rdata, disp_rdata);
        end
        cyc();
        cyc();
        total++;
        if (ram[16'h0700] !== pat(16'h0700)) begin
            bad++; $display("FAIL rst_write_lost: got %h want %h", ram[16'h0700], pat(16'h0700));
        end
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0701; cpu_wdata = 8'h11;
        @(negedge clk);
        total++;
        if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL rst_first_write_gnt: got %b want 1", cpu_gnt); end
        cyc();
        idle();
        cyc(); cyc();
    endtask

    task automatic test_disp_only();
        for (int i = 0; i < 4; i++) begin
            disp_req  = 1'b1;
            disp_addr = 16'h0200 + 16'(i);
            @(negedge clk);
            total++;
            if (disp_gnt !== 1'b1) begin bad++; $display("FAIL disp_only_gnt[%0d]: got %b want 1", i, disp_gnt); end
            cyc();
        end
        idle();
        cyc(); cyc();
    endtask

    task automatic test_starvation();
        int n_disp = 0;
        bit got = 0;
        disp_req = 1'b1; disp_addr = 16'h0500;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (cpu_gnt) begin
                got = 1;
                total++;
                if (disp_gnt !== 1'b0 || mem_addr !== 16'h0010) begin
                    bad++; $display("FAIL starve_slot: got dg=%b ma=%h want dg=0 ma=0010", disp_gnt, mem_addr);
                end
            end else if (disp_gnt) begin
                n_disp++;
            end
            cyc();
            disp_addr = disp_addr + 16'd1;
            if (got) cpu_req = 1'b0;
        end
        total++;
        if (!got) begin bad++; $display("FAIL starve_timeout: got no cpu_gnt want grant"); end
        total++;
        if (n_disp != 8) begin bad++; $display("FAIL starve_run: got %0d want 8", n_disp); end
        @(negedge clk);
        total++;
        if (disp_gnt !== 1'b1) begin bad++; $display("FAIL starve_resume: got %b want 1", disp_gnt); end
`ifdef VRAM_ARB_STATS_EN
        total++;
        if (stall_cnt !== 16'd8) begin bad++; $display("FAIL stats_starve: got %0d want 8", stall_cnt); end
`endif
        cyc();
        idle();
        cyc(); cyc();
    endtask

    task automatic test_posted_write();
        int stalls = 0;
        bit got = 0;
        disp_req = 1'b1; disp_addr = 16'h0600;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 8'hA5;
        @(negedge clk);
        total++;
        if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL posted_gnt: got %b want 1", cpu_gnt); end
        cyc();
        disp_addr = disp_addr + 16'd1;
        cpu_addr = 16'h0301; cpu_wdata = 8'h5A;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (cpu_gnt) begin
                got = 1;
                total++;
                if (mem_we !== 1'b1 || mem_addr !== 16'h0300) begin
                    bad++; $display("FAIL posted_drain: got we=%b ma=%h want we=1 ma=0300", mem_we, mem_addr);
                end
            end else begin
                stalls++;
            end
            cyc();
            disp_addr = disp_addr + 16'd1;
            if (got) cpu_req = 1'b0;
        end
        total++;
        if (!got || stalls != 8) begin bad++; $display("FAIL posted_stall: got %0d want 8", stalls); end
        @(negedge clk);
        total++;
        if (ram[16'h0300] !== 8'hA5) begin bad++; $display("FAIL posted_ram0300: got %h want a5", ram[16'h0300]); end
        for (int c = 0; c < 12; c++) begin
            cyc();
            disp_addr = disp_addr + 16'd1;
        end
        idle();
        cyc(); cyc(); cyc();
        @(negedge clk);
        total++;
        if (ram[16'h0301] !== 8'h5A) begin bad++; $display("FAIL posted_ram0301: got %h want 5a", ram[16'h0301]); end
        cyc();
    endtask

    task automatic test_forward();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0400; cpu_wdata = 8'h3C;
        @(negedge clk);
        total++;
        if (cpu_gnt !== 1'b1 || mem_we !== 1'b0) begin
            bad++; $display("FAIL fwd_write: got gnt=%b we=%b want gnt=1 we=0", cpu_gnt, mem_we);
        end
        cyc();
        cpu_we = 1'b0;
        @(negedge clk);
        total++;
        if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL fwd_read_gnt: got %b want 1", cpu_gnt); end
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h0400) begin
            bad++; $display("FAIL fwd_drain_slot: got we=%b ma=%h want we=1 ma=0400", mem_we, mem_addr);
        end
        cyc();
        cpu_req = 1'b0;
        @(negedge clk);
        total++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h3C) begin
            bad++; $display("FAIL fwd_rdata: got rv=%b d=%h want rv=1 d=3c", cpu_rvalid, cpu_rdata);
        end
        total++;
        if (mem_we !== 1'b0 || mem_addr !== 16'h0400) begin
            bad++; $display("FAIL idle_hold: got we=%b ma=%h want we=0 ma=0400", mem_we, mem_addr);
        end
        cyc(); cyc();
    endtask

    task automatic test_withdraw();
        int seen = 0;
        disp_req = 1'b1; disp_addr = 16'h0800;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (cpu_gnt !== 1'b0) begin bad++; $display("FAIL withdraw_gnt[%0d]: got %b want 0", c, cpu_gnt); end
            cyc();
            disp_addr = disp_addr + 16'd1;
        end
        cpu_req = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (cpu_rvalid) seen++;
            if (c == 3) disp_req = 1'b0;
            cyc();
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL withdraw_rvalid: got %0d want 0", seen); end
    endtask

`ifdef VRAM_ARB_STATS_EN
    task automatic test_stats();
        disp_req = 1'b1; disp_addr = 16'h0900;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
        repeat (75000) cyc();
        idle();
        cyc(); cyc();
        @(negedge clk);
        total++;
        if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL stats_sat: got %h want ffff", stall_cnt); end
        cyc();
    endtask
`endif

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]    = pat(16'(i));
            golden[i] = pat(16'(i));
        end
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        disp_req = 1'b0; disp_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
        test_reset();
        test_disp_only();
        test_starvation();
        test_posted_write();
        test_forward();
        test_withdraw();
`ifdef VRAM_ARB_STATS_EN
        test_stats();
`endif
        cyc(); cyc();
        total++;
        if (dq.size() != 0 || cq.size() != 0) begin
            bad++; $display("FAIL leftover_reads: got disp=%0d cpu=%0d want 0 0", dq.size(), cq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
